// File: rtl/conv_kxk_mac.sv
// KxK patch/kernel dot product using one time-multiplexed multiplier, one tap per cycle.
// Optionally accumulates across several beats (input channels) before emitting a result.
module conv_kxk_mac #(
   parameter int unsigned K      = 3,
   parameter int unsigned DW     = 16,
   parameter int unsigned OW     = 64,
   parameter bit          SIGNED = 1'b0
) (
   input  logic                CLK,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_first,
   input  logic                in_last,
   input  logic [K*K*DW-1:0]   PATCH,
   input  logic [K*K*DW-1:0]   KERNEL,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OW-1:0]       RESULT,
   output logic                busy
);

   localparam int unsigned N  = K * K;
   localparam int unsigned TW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PW = 2 * DW;
   localparam logic [TW-1:0] LAST_TAP = TW'(N - 1);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t          state;
   logic [N*DW-1:0] p_lat;
   logic [N*DW-1:0] k_lat;
   logic            last_lat;
   logic [TW-1:0]   tap;
   logic [OW-1:0]   acc;
   logic [OW-1:0]   acc_nxt;
   logic [OW-1:0]   prod_ext;
   logic [PW-1:0]   prod;
   logic [DW-1:0]   p_tap;
   logic [DW-1:0]   k_tap;
   logic [DW-1:0]   p_arr [N];
   logic [DW-1:0]   k_arr [N];

   for (genvar i = 0; i < N; i++) begin : g_tap
      assign p_arr[i] = p_lat[i*DW +: DW];
      assign k_arr[i] = k_lat[i*DW +: DW];
   end

   assign p_tap = p_arr[tap];
   assign k_tap = k_arr[tap];

   // Extend operands to a full-width product, then the product to the accumulator width.
   if (SIGNED) begin : g_signed
      logic signed [PW-1:0] prod_s;
      assign prod_s   = PW'($signed(p_tap)) * PW'($signed(k_tap));
      assign prod     = prod_s;
      assign prod_ext = OW'($signed(prod));
   end else begin : g_unsigned
      assign prod     = PW'(p_tap) * PW'(k_tap);
      assign prod_ext = OW'(prod);
   end

   assign acc_nxt = acc + prod_ext;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         RESULT    <= '0;
         busy      <= 1'b0;
         acc       <= '0;
         tap       <= '0;
         p_lat     <= '0;
         k_lat     <= '0;
         last_lat  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  p_lat    <= PATCH;
                  k_lat    <= KERNEL;
                  last_lat <= in_last;
                  if (in_first) acc <= '0;
                  tap      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc <= acc_nxt;
               tap <= tap + TW'(1);
               if (tap == LAST_TAP) begin
                  if (last_lat) begin
                     RESULT    <= acc_nxt;
                     out_valid <= 1'b1;
                     state     <= OUT;
                  end else begin
                     in_ready <= 1'b1;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_kxk_mac.sv
// Self-checking bench: three conv_kxk_mac variants (unsigned/64, signed/64, unsigned/32) driven in lockstep.
module tb_conv_kxk_mac;

   localparam int unsigned NB = 9 * 16;

   logic          CLK;
   logic          rst_n;
   logic          in_valid;
   logic          in_first;
   logic          in_last;
   logic [NB-1:0] PATCH;
   logic [NB-1:0] KERNEL;
   logic          out_ready;

   logic          in_ready,   out_valid,   busy;
   logic [63:0]   RESULT;
   logic          in_ready_s, out_valid_s, busy_s;
   logic [63:0]   RESULT_s;
   logic          in_ready_n, out_valid_n, busy_n;
   logic [31:0]   RESULT_n;

   int vectors    = 0;
   int miscompares = 0;

   conv_kxk_mac #(.K(3), .DW(16), .OW(64), .SIGNED(1'b0)) u_u64 (
      .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_first(in_first), .in_last(in_last), .PATCH(PATCH), .KERNEL(KERNEL),
      .out_valid(out_valid), .out_ready(out_ready), .RESULT(RESULT), .busy(busy));

   conv_kxk_mac #(.K(3), .DW(16), .OW(64), .SIGNED(1'b1)) u_s64 (
      .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_first(in_first), .in_last(in_last), .PATCH(PATCH), .KERNEL(KERNEL),
      .out_valid(out_valid_s), .out_ready(out_ready), .RESULT(RESULT_s), .busy(busy_s));

   conv_kxk_mac #(.K(3), .DW(16), .OW(32), .SIGNED(1'b0)) u_u32 (
      .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
      .in_first(in_first), .in_last(in_last), .PATCH(PATCH), .KERNEL(KERNEL),
      .out_valid(out_valid_n), .out_ready(out_ready), .RESULT(RESULT_n), .busy(busy_n));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [NB-1:0] p;
      logic [NB-1:0] k;
      logic          first;
      logic          last;
      logic [63:0]   eu;
      logic [63:0]   es;
      logic [31:0]   e32;
   } vec_t;

   vec_t tbl [5];

   function automatic logic [NB-1:0] ramp(input int base);
      logic [NB-1:0] v;
      for (int t = 0; t < 9; t++) v[t*16 +: 16] = 16'(base + t);
      return v;
   endfunction

   function automatic logic [NB-1:0] fill(input logic [15:0] x);
      logic [NB-1:0] v;
      for (int t = 0; t < 9; t++) v[t*16 +: 16] = x;
      return v;
   endfunction

   // Plain-arithmetic dot product of one beat; 64-bit wrap comes from longint.
   function automatic logic [63:0] dot(input logic [NB-1:0] p, input logic [NB-1:0] k, input bit sg);
      longint s = 0;
      longint a, b;
      for (int t = 0; t < 9; t++) begin
         if (sg) begin
            a = longint'($signed(p[t*16 +: 16]));
            b = longint'($signed(k[t*16 +: 16]));
         end else begin
            a = longint'(p[t*16 +: 16]);
            b = longint'(k[t*16 +: 16]);
         end
         s += a * b;
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
      end
   endtask

   // Present a beat, hold until accepted, then scramble inputs to show they are not re-sampled.
   task automatic send_beat(input logic [NB-1:0] p, input logic [NB-1:0] k, input logic f, input logic l);
      bit ok = 1'b0;
      @(negedge CLK);
      PATCH = p; KERNEL = k; in_first = f; in_last = l; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin ok = 1'b1; break; end
         @(negedge CLK);
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      PATCH    = {5{$urandom}};
      KERNEL   = {5{$urandom}};
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic get_result(input bit rand_rdy, output logic [63:0] gu, output logic [63:0] gs,
                             output logic [31:0] g32);
      bit ok = 1'b0;
      gu = '0; gs = '0; g32 = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            gu = RESULT; gs = RESULT_s; g32 = RESULT_n;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("result_timeout", 64'd0, 64'd1);
      @(posedge CLK);
      #1;
      out_ready = 1'b1;
   endtask

   logic [63:0] gu, gs, r0;
   logic [31:0] g32;
   longint      acc_u, acc_s;
   int          lat;
   bit          flag;

   initial begin
      tbl[0] = '{ramp(0), ramp(9), 1'b1, 1'b1, 64'd528, 64'd528, 32'd528};
      tbl[1] = '{fill(16'hFFFF), fill(16'd2), 1'b1, 1'b1, 64'd1179630, 64'hFFFF_FFFF_FFFF_FFEE, 32'd1179630};
      tbl[2] = '{fill(16'hFFFF), fill(16'hFFFF), 1'b1, 1'b1, 64'h0000_0008_FFEE_0009, 64'd9, 32'hFFEE_0009};
      tbl[3] = '{fill(16'hFFFF), fill(16'hFFFF), 1'b0, 1'b1, 64'h0000_0011_FFDC_0012, 64'd18, 32'hFFDC_0012};
      tbl[4] = '{ramp(0), ramp(9), 1'b0, 1'b1, 64'h0000_0011_FFDC_0222, 64'd546, 32'hFFDC_0222};

      rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      PATCH = '0; KERNEL = '0; out_ready = 1'b1;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", RESULT, 64'd0);
      @(negedge CLK);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         send_beat(tbl[i].p, tbl[i].k, tbl[i].first, tbl[i].last);
         get_result(1'b0, gu, gs, g32);
         check($sformatf("tbl%0d_u64", i), gu, tbl[i].eu);
         check($sformatf("tbl%0d_s64", i), gs, tbl[i].es);
         check($sformatf("tbl%0d_u32", i), 64'(g32), 64'(tbl[i].e32));
      end

      // Latency: out_valid after the 9th edge, in_ready back the edge after the handshake.
      out_ready = 1'b1;
      send_beat(ramp(0), ramp(9), 1'b1, 1'b1);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK);
         #1;
         if (out_valid) begin lat = i; break; end
      end
      check("latency", 64'(lat), 64'd9);
      check("lat_result", RESULT, 64'd528);
      check("lat_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge CLK);
      #1;
      check("lat_in_ready_back", 64'(in_ready), 64'd1);
      check("lat_out_valid_drop", 64'(out_valid), 64'd0);

      // Two-beat accumulation: no result after the first beat.
      send_beat(ramp(0), ramp(9), 1'b1, 1'b0);
      flag = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (out_valid) flag = 1'b1;
         if (in_ready) break;
      end
      check("two_beat_no_early_valid", 64'(flag), 64'd0);
      send_beat(ramp(0), ramp(9), 1'b0, 1'b1);
      get_result(1'b0, gu, gs, g32);
      check("two_beat_u64", gu, 64'd1056);
      check("two_beat_u32", 64'(g32), 64'd1056);

      // Backpressure: result held, pending beat refused until the handshake.
      out_ready = 1'b0;
      send_beat(ramp(0), ramp(9), 1'b1, 1'b1);
      flag = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (out_valid) begin flag = 1'b1; break; end
      end
      check("bp_valid_seen", 64'(flag), 64'd1);
      r0 = RESULT;
      check("bp_result", r0, 64'd528);
      PATCH = fill(16'hFFFF); KERNEL = fill(16'd2); in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
      flag = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (!(out_valid && RESULT == r0 && !in_ready && busy)) flag = 1'b0;
      end
      check("bp_stable", 64'(flag), 64'd1);
      out_ready = 1'b1;
      @(negedge CLK);
      check("bp_in_ready_after", 64'(in_ready), 64'd1);
      check("bp_busy_after", 64'(busy), 64'd0);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      get_result(1'b0, gu, gs, g32);
      check("bp_next_u64", gu, 64'd1179630);
      check("bp_next_s64", gs, 64'hFFFF_FFFF_FFFF_FFEE);

      // Asynchronous reset mid-MAC, then a fresh beat that relies on the cleared accumulator.
      send_beat(fill(16'h1234), fill(16'h4321), 1'b1, 1'b1);
      repeat (3) @(posedge CLK);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_result", RESULT, 64'd0);
      @(negedge CLK);
      rst_n = 1'b1;
      send_beat(ramp(0), ramp(9), 1'b0, 1'b1);
      get_result(1'b0, gu, gs, g32);
      check("arst_fresh_u64", gu, 64'd528);
      check("arst_fresh_s64", gs, 64'd528);

      // Random beats against the reference model, with random downstream stalls.
      acc_u = 0; acc_s = 0;
      for (int i = 0; i < 24; i++) begin
         logic [NB-1:0] p, k;
         logic f, l;
         p = {5{$urandom}};
         k = {5{$urandom}};
         f = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         l = (i == 23) ? 1'b1 : 1'($urandom_range(0, 1));
         if (f) begin acc_u = 0; acc_s = 0; end
         acc_u += longint'(dot(p, k, 1'b0));
         acc_s += longint'(dot(p, k, 1'b1));
         send_beat(p, k, f, l);
         if (l) begin
            get_result(1'b1, gu, gs, g32);
            check($sformatf("rnd%0d_u64", i), gu, 64'(acc_u));
            check($sformatf("rnd%0d_s64", i), gs, 64'(acc_s));
            check($sformatf("rnd%0d_u32", i), 64'(g32), 64'(acc_u) & 64'hFFFF_FFFF);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
